// File: rtl/gestor_alarma_pkg.sv
// Shared types and constants for the alarm manager.
package alarma_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SOSPECHA = 2'd1,
        ALARMA   = 2'd2,
        RECUPERA = 2'd3
    } estado_alarma_t;

    localparam logic [7:0] EVENTOS_MAX      = 8'd255;
    localparam int         N_ACTIVAR_DEF    = 4;
    localparam int         N_DESACTIVAR_DEF = 4;
    localparam int         DIV_PARPADEO_DEF = 25_000_000;

endpackage

// File: rtl/gestor_alarma_if.sv
// Sample/acknowledge inputs and user-facing alarm outputs of the alarm manager.
interface gestor_alarma_if;

    logic       muestra_valida;
    logic       fuera_rango;
    logic       reconocer;
    logic       alarma;
    logic       led_alarma;
    logic       buzzer;
    logic [1:0] estado;
    logic [7:0] n_eventos;

    // Producer of samples/acknowledge, consumer of the alarm outputs.
    modport master (
        output muestra_valida, fuera_rango, reconocer,
        input  alarma, led_alarma, buzzer, estado, n_eventos
    );

    // The alarm manager itself.
    modport slave (
        input  muestra_valida, fuera_rango, reconocer,
        output alarma, led_alarma, buzzer, estado, n_eventos
    );

endinterface

// File: rtl/gestor_alarma_parpadeo.sv
// LED blink generator: toggles its output every DIV enabled cycles and
// parks at 1 with a cleared counter while disabled, so every blink
// sequence starts high with a deterministic phase.
module generador_parpadeo #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic habilitar,
    output logic salida
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         salida_q;
    logic         salida_d;

    // Next counter/toggle value: hold at reset phase while disabled.
    always_comb begin
        cnt_d    = cnt_q;
        salida_d = salida_q;
        if (!habilitar) begin
            cnt_d    = '0;
            salida_d = 1'b1;
        end else if (cnt_q == ULTIMO) begin
            cnt_d    = '0;
            salida_d = ~salida_q;
        end else begin
            cnt_d    = cnt_q + {{(W-1){1'b0}}, 1'b1};
            salida_d = salida_q;
        end
    end

    // Counter and toggle flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            salida_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
        end
    end

    assign salida = salida_q;

endmodule

// File: rtl/gestor_alarma.sv
// Alarm manager: qualifies the comparator's out-of-range flag with
// consecutive-sample persistence and drives LED, buzzer and event count.
module gestor_alarma
    import alarma_pkg::*;
#(
    parameter int N_ACTIVAR    = N_ACTIVAR_DEF,
    parameter int N_DESACTIVAR = N_DESACTIVAR_DEF,
    parameter int DIV_PARPADEO = DIV_PARPADEO_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    gestor_alarma_if.slave  bus
);

    localparam logic [3:0] N_ACT_C = 4'(N_ACTIVAR);
    localparam logic [3:0] N_DES_C = 4'(N_DESACTIVAR);

    estado_alarma_t estado_q;
    estado_alarma_t estado_d;
    logic [3:0]     cnt_q;
    logic [3:0]     cnt_d;
    logic           evento_s;

    logic           alarma_q;
    logic           alarma_d;
    logic           buzzer_q;
    logic           buzzer_d;
    logic           ack_q;
    logic           ack_d;
    logic [7:0]     n_eventos_q;
    logic [7:0]     n_eventos_d;
    logic           parpadeo_s;

    // State register: FSM state and persistence counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= NORMAL;
            cnt_q    <= 4'd0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic, advanced only on valid samples.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        evento_s = 1'b0;
        if (bus.muestra_valida) begin
            case (estado_q)
                NORMAL: begin
                    if (bus.fuera_rango) begin
                        if (N_ACT_C == 4'd1) begin
                            estado_d = ALARMA;
                            cnt_d    = 4'd0;
                            evento_s = 1'b1;
                        end else begin
                            estado_d = SOSPECHA;
                            cnt_d    = 4'd1;
                        end
                    end else begin
                        estado_d = NORMAL;
                    end
                end
                SOSPECHA: begin
                    if (bus.fuera_rango) begin
                        if (cnt_q + 4'd1 == N_ACT_C) begin
                            estado_d = ALARMA;
                            cnt_d    = 4'd0;
                            evento_s = 1'b1;
                        end else begin
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end else begin
                        estado_d = NORMAL;
                        cnt_d    = 4'd0;
                    end
                end
                ALARMA: begin
                    if (!bus.fuera_rango) begin
                        if (N_DES_C == 4'd1) begin
                            estado_d = NORMAL;
                            cnt_d    = 4'd0;
                        end else begin
                            estado_d = RECUPERA;
                            cnt_d    = 4'd1;
                        end
                    end else begin
                        estado_d = ALARMA;
                    end
                end
                RECUPERA: begin
                    if (!bus.fuera_rango) begin
                        if (cnt_q + 4'd1 == N_DES_C) begin
                            estado_d = NORMAL;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end else begin
                        // Relapse during recovery: same event, no new count.
                        estado_d = ALARMA;
                        cnt_d    = 4'd0;
                    end
                end
                default: begin
                    estado_d = NORMAL;
                    cnt_d    = 4'd0;
                end
            endcase
        end else begin
            estado_d = estado_q;
        end
    end

    // Output logic: next values of alarm level, acknowledge, buzzer, event count.
    always_comb begin
        alarma_d = (estado_d == ALARMA) || (estado_d == RECUPERA);

        // A new event or a return to NORMAL clears the flag and wins over reconocer.
        if (evento_s || (estado_d == NORMAL)) begin
            ack_d = 1'b0;
        end else if (bus.reconocer && alarma_q) begin
            ack_d = 1'b1;
        end else begin
            ack_d = ack_q;
        end

        buzzer_d = alarma_d & ~ack_d;

        if (evento_s && (n_eventos_q != EVENTOS_MAX)) begin
            n_eventos_d = n_eventos_q + 8'd1;
        end else begin
            n_eventos_d = n_eventos_q;
        end
    end

    // Output register so every user-facing signal comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarma_q    <= 1'b0;
            buzzer_q    <= 1'b0;
            ack_q       <= 1'b0;
            n_eventos_q <= 8'd0;
        end else begin
            alarma_q    <= alarma_d;
            buzzer_q    <= buzzer_d;
            ack_q       <= ack_d;
            n_eventos_q <= n_eventos_d;
        end
    end

    // Blinking only while the alarm is up and not yet acknowledged.
    generador_parpadeo #(
        .DIV (DIV_PARPADEO)
    ) u_parpadeo (
        .clk       (clk),
        .rst_n     (rst_n),
        .habilitar (alarma_q & ~ack_q),
        .salida    (parpadeo_s)
    );

    assign bus.alarma     = alarma_q;
    assign bus.buzzer     = buzzer_q;
    assign bus.led_alarma = alarma_q & (ack_q | parpadeo_s);
    assign bus.estado     = estado_q;
    assign bus.n_eventos  = n_eventos_q;

endmodule

// File: doc/gestor_alarma.md
Name: gestor_alarma

Overview:
- Downstream consumer of the temperature range comparator's `fuera_rango` flag.
- Qualifies the flag with consecutive-sample persistence: N out-of-range samples raise the alarm, M in-range samples clear it.
- Drives the user-facing alarm: blinking LED, buzzer and acknowledge button, plus a saturating count of alarm events.
- Sits between the comparator and the board indicator/peripheral logic.

Parameters:
- N_ACTIVAR, 4: consecutive out-of-range samples needed to raise the alarm (legal range 1..15).
- N_DESACTIVAR, 4: consecutive in-range samples needed to clear the alarm (legal range 1..15).
- DIV_PARPADEO, 25_000_000: clock cycles per LED half-period while the alarm is unacknowledged (≥2).

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- muestra_valida  input  1  one-cycle strobe: new registered temperature sample available.
- fuera_rango  input  1  comparator result for the current sample; only meaningful when muestra_valida=1.
- reconocer  input  1  acknowledge pulse from a debounced button; one cycle wide.
- alarma  output  1  qualified alarm level.
- led_alarma  output  1  indicator LED.
- buzzer  output  1  audible alarm enable.
- estado  output  2  current FSM state, for debug.
- n_eventos  output  8  count of alarm events, saturating at 255.

Behaviour:
- Reset: the asynchronous assertion of rst_n forces every output and internal register to 0.
  - FSM goes to NORMAL; persistence counter, acknowledge flag and blink counter clear.
  - Reset mid-alarm drops all outputs at once; n_eventos clears to 0.
- Sampling: inputs are evaluated only on clock edges where muestra_valida=1. fuera_rango is ignored otherwise.
- Outputs: all registered. They reflect a sample on the cycle after the edge that captured it (1-cycle latency).
- FSM (estado encoding: NORMAL=0, SOSPECHA=1, ALARMA=2, RECUPERA=3), on valid samples only:
  - NORMAL:
    - fuera=1: cnt←1, go to SOSPECHA. If N_ACTIVAR=1, go straight to ALARMA (new event).
    - fuera=0: stay.
  - SOSPECHA:
    - fuera=1: cnt++. When cnt+1=N_ACTIVAR, go to ALARMA (new event) and cnt←0.
    - fuera=0: cnt←0, go to NORMAL.
  - ALARMA:
    - fuera=0: cnt←1, go to RECUPERA. If N_DESACTIVAR=1, go straight to NORMAL.
    - fuera=1: stay.
  - RECUPERA:
    - fuera=0: cnt++. When cnt+1=N_DESACTIVAR, go to NORMAL and cnt←0.
    - fuera=1: cnt←0, go back to ALARMA. This is NOT a new event.
- alarma = 1 in ALARMA and in RECUPERA.
- New event (entry into ALARMA from NORMAL or SOSPECHA):
  - n_eventos increments, holding at 255.
  - The acknowledge flag clears.
- Acknowledge flag:
  - Set by reconocer=1 while alarma=1. reconocer while alarma=0 is ignored.
  - Cleared on every entry to NORMAL.
  - If reconocer and a new-event transition occur on the same edge, the clear wins (flag ends 0).
- buzzer = alarma AND NOT acknowledged.
- led_alarma:
  - Alarm active, not acknowledged: toggles every DIV_PARPADEO cycles. Starts at 1 on the first cycle of the alarm; the blink counter restarts at the alarm's start.
  - Alarm active, acknowledged: steady 1.
  - Otherwise: 0.
- Blink counter is held at 0 whenever the LED is not blinking, which saves power and makes the phase deterministic.
- Persistence counter width is 4 bits. It never exceeds max(N_ACTIVAR, N_DESACTIVAR).

Decomposition:
- Package alarma_pkg holds:
  - typedef enum logic [1:0] estado_alarma_t {NORMAL, SOSPECHA, ALARMA, RECUPERA};
  - localparam EVENTOS_MAX=8'd255;
  - default values for N_ACTIVAR and N_DESACTIVAR.
- One sub-module, generador_parpadeo:
  - Parameter DIV.
  - Inputs clk, rst_n, habilitar.
  - Output salida.
  - Counter plus toggle flop. When habilitar=0: counter←0, salida←1. It is instantiated once.

Test Plan:
Simulation uses N_ACTIVAR=3, N_DESACTIVAR=2, DIV_PARPADEO=4, with valid samples every 5 cycles.
1. Glitch rejection: samples fuera = 1,1,0,1,1,0 → alarma stays 0; estado visits 1 and returns to 0; n_eventos=0.
2. Alarm raise: 3 consecutive fuera=1 → on the cycle after the 3rd valid edge, alarma=1, buzzer=1, led=1, estado=2, n_eventos=1. The LED then toggles every 4 cycles.
3. Acknowledge and hysteresis:
   - Pulse reconocer during the alarm → buzzer=0, led steady 1.
   - Then fuera = 0,1 → estado goes 3 then 2; alarma stays 1; n_eventos stays 1; buzzer stays 0.
   - Then fuera = 0,0 → alarma=0, led=0, estado=0.
4. Ignored inputs:
   - reconocer in NORMAL, then a new alarm → buzzer=1, so the flag was not pre-set.
   - fuera toggled with muestra_valida=0 → no state change.
5. Saturation: force 256 raise/clear cycles → n_eventos=255 and holds.
6. Reset: assert rst_n=0 mid-ALARMA, asynchronously between edges → all outputs 0 immediately. After release, the first fuera=1 sample moves estado to 1, not 2.
